// File: rtl/imem_arb_if.sv
// -----------------------------------------------------------------------------
// imem_arb_if
// Bundle of the fetch, debug and instruction-memory signals around imem_arb.
//   f_req/f_adr      : fetch read request and byte address
//   f_gnt            : fetch request accepted this cycle
//   f_rvalid/f_rdata/f_err : fetch response (one cycle after grant)
//   d_*              : the same set for the debug/test read port
//   mem_adr          : byte address presented to the memory read port
//   mem_rd           : combinational read data returned by the memory
// Modports:
//   slave  - the arbiter side
//   master - the requesters plus the memory model
// -----------------------------------------------------------------------------
interface imem_arb_if;
   logic        f_req;
   logic [31:0] f_adr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        f_err;
   logic        d_req;
   logic [31:0] d_adr;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] mem_adr;
   logic [31:0] mem_rd;

   modport slave (
      input  f_req, f_adr, d_req, d_adr, mem_rd,
      output f_gnt, f_rvalid, f_rdata, f_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_adr
   );

   modport master (
      output f_req, f_adr, d_req, d_adr, mem_rd,
      input  f_gnt, f_rvalid, f_rdata, f_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_adr
   );
endinterface

// File: rtl/imem_arb.sv
// -----------------------------------------------------------------------------
// imem_arb
// Shares the single combinational read port of the instruction memory between
// the fetch stage and a debug/test port. At most one read is granted per
// cycle; the granted side receives registered data one cycle later. Fetch has
// priority, but after MAX_WAIT consecutive lost contentions debug wins once.
// Out-of-range or misaligned addresses return err=1 with zero data.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - imem_arb_if.slave (fetch, debug and memory signals)
// Parameters:
//   SIZE     - memory depth in 32-bit words
//   MAX_WAIT - debug-losing cycles before debug wins a contention (1..15)
// -----------------------------------------------------------------------------
module imem_arb #(
   parameter int unsigned SIZE     = 64,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   imem_arb_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      F_RESP = 2'd1,
      D_RESP = 2'd2
   } state_t;

   localparam logic [3:0]  MAX_WAIT_C = 4'(MAX_WAIT);
   localparam logic [31:0] SIZE_C     = 32'(SIZE);

   // Address error check: word index out of range or not word aligned.
   // All upper bits take part, so a high alias is never treated as valid.
   function automatic logic adr_err(input logic [31:0] adr);
      adr_err = ({2'b00, adr[31:2]} >= SIZE_C) || (adr[1:0] != 2'b00);
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  wait_cnt_r;
   logic [3:0]  wait_cnt_nxt_s;

   logic        f_gnt_s;
   logic        d_gnt_s;
   logic [31:0] mem_adr_s;
   logic        gnt_err_s;
   logic [31:0] gnt_data_s;

   logic        f_rvalid_r;
   logic [31:0] f_rdata_r;
   logic        f_err_r;
   logic        d_rvalid_r;
   logic [31:0] d_rdata_r;
   logic        d_err_r;

   // Grant decision: fetch first, debug on starvation; nothing during reset.
   always_comb begin
      f_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
      if (!reset) begin
         f_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end else if (bus.f_req && bus.d_req) begin
         if (wait_cnt_r == MAX_WAIT_C) begin
            d_gnt_s = 1'b1;
         end else begin
            f_gnt_s = 1'b1;
         end
      end else if (bus.f_req) begin
         f_gnt_s = 1'b1;
      end else if (bus.d_req) begin
         d_gnt_s = 1'b1;
      end else begin
         f_gnt_s = 1'b0;
         d_gnt_s = 1'b0;
      end
   end

   // Address mux: idle cycles park on the fetch address to keep it stable.
   always_comb begin
      mem_adr_s = bus.f_adr;
      if (d_gnt_s) begin
         mem_adr_s = bus.d_adr;
      end else begin
         mem_adr_s = bus.f_adr;
      end
   end

   // Response data for the granted address; errors never expose memory data.
   always_comb begin
      gnt_err_s  = adr_err(mem_adr_s);
      gnt_data_s = 32'h0000_0000;
      if (gnt_err_s) begin
         gnt_data_s = 32'h0000_0000;
      end else begin
         gnt_data_s = bus.mem_rd;
      end
   end

   // Starvation counter: counts debug losses, saturating, cleared otherwise.
   always_comb begin
      wait_cnt_nxt_s = 4'd0;
      if (bus.d_req && f_gnt_s) begin
         if (wait_cnt_r >= MAX_WAIT_C) begin
            wait_cnt_nxt_s = MAX_WAIT_C;
         end else begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
         end
      end else begin
         wait_cnt_nxt_s = 4'd0;
      end
   end

   // Next state: owner of the response presented in the following cycle.
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE, F_RESP, D_RESP: begin
            if (f_gnt_s) begin
               state_nxt_s = F_RESP;
            end else if (d_gnt_s) begin
               state_nxt_s = D_RESP;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register and starvation counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         wait_cnt_r <= 4'd0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
      end
   end

   // Response registers: valid/err pulse for one cycle, data holds otherwise.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f_rvalid_r <= 1'b0;
         f_err_r    <= 1'b0;
         f_rdata_r  <= 32'h0000_0000;
         d_rvalid_r <= 1'b0;
         d_err_r    <= 1'b0;
         d_rdata_r  <= 32'h0000_0000;
      end else begin
         f_rvalid_r <= (state_nxt_s == F_RESP);
         f_err_r    <= (state_nxt_s == F_RESP) && gnt_err_s;
         d_rvalid_r <= (state_nxt_s == D_RESP);
         d_err_r    <= (state_nxt_s == D_RESP) && gnt_err_s;
         if (state_nxt_s == F_RESP) begin
            f_rdata_r <= gnt_data_s;
         end
         if (state_nxt_s == D_RESP) begin
            d_rdata_r <= gnt_data_s;
         end
      end
   end

   assign bus.f_gnt    = f_gnt_s;
   assign bus.d_gnt    = d_gnt_s;
   assign bus.mem_adr  = mem_adr_s;
   assign bus.f_rvalid = f_rvalid_r;
   assign bus.f_rdata  = f_rdata_r;
   assign bus.f_err    = f_err_r;
   assign bus.d_rvalid = d_rvalid_r;
   assign bus.d_rdata  = d_rdata_r;
   assign bus.d_err    = d_err_r;

endmodule

// File: tb/tb_imem_arb.sv
// -----------------------------------------------------------------------------
// tb_imem_arb
// Scoreboard bench for imem_arb: the driver predicts grants from the arbiter
// rules and queues the expected response per side; an independent monitor
// pops and compares whenever a response is presented.
// -----------------------------------------------------------------------------
module tb_imem_arb;
   localparam int SIZE     = 64;
   localparam int MAX_WAIT = 4;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } resp_t;

   logic clk;
   logic reset;
   imem_arb_if ifc ();

   imem_arb #(.SIZE(SIZE), .MAX_WAIT(MAX_WAIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   logic [31:0] mem [SIZE];
   assign ifc.mem_rd = (ifc.mem_adr[31:2] < SIZE) ? mem[ifc.mem_adr[7:2]] : 32'hDEAD_BEEF;

   int    errors;
   int    checks;
   int    cnt_m;
   resp_t fq[$];
   resp_t dq[$];
   resp_t mon_r;
   logic [31:0] last_f;
   logic [31:0] last_d;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic resp_t model_resp(input logic [31:0] a);
      resp_t r;
      longint unsigned w;
      w = longint'(a) / 4;
      if (w >= SIZE || (a % 4) != 0) begin
         r.err  = 1'b1;
         r.data = 32'h0;
      end else begin
         r.err  = 1'b0;
         r.data = mem[int'(w)];
      end
      return r;
   endfunction

   // One cycle: drive requests, predict and check grants at the falling edge.
   task automatic cycle(input logic fr, input logic [31:0] fa, input logic dr,
                        input logic [31:0] da, output logic gf, output logic gd);
      logic fg;
      logic dg;
      ifc.f_req = fr; ifc.f_adr = fa;
      ifc.d_req = dr; ifc.d_adr = da;
      @(negedge clk);
      fg = reset && fr && !(dr && cnt_m == MAX_WAIT);
      dg = reset && dr && !fg;
      gf = ifc.f_gnt;
      gd = ifc.d_gnt;
      chk("f_gnt", {31'b0, ifc.f_gnt}, {31'b0, fg});
      chk("d_gnt", {31'b0, ifc.d_gnt}, {31'b0, dg});
      chk("mem_adr", ifc.mem_adr, dg ? da : fa);
      if (fg) fq.push_back(model_resp(fa));
      if (dg) dq.push_back(model_resp(da));
      if (!reset) cnt_m = 0;
      else if (dr && fg) cnt_m = (cnt_m + 1 > MAX_WAIT) ? MAX_WAIT : cnt_m + 1;
      else cnt_m = 0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_adr();
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0, 1, 2: a = 32'($urandom_range(0, SIZE - 1)) << 2;
         3:       a = ($urandom_range(0, 1) == 0) ? 32'(4 * SIZE - 4) : 32'(4 * SIZE);
         4:       a = (32'($urandom_range(0, SIZE - 1)) << 2) | 32'($urandom_range(1, 3));
         default: a = $urandom;
      endcase
      return a;
   endfunction

   // Monitor: compare every presented response against the scoreboard.
   always @(negedge clk) begin
      if (ifc.f_rvalid === 1'b1) begin
         if (fq.size() == 0) begin
            checks++; errors++;
            $display("FAIL f_unexpected_rvalid actual=1 expected=0");
         end else begin
            mon_r = fq.pop_front();
            chk("f_rdata", ifc.f_rdata, mon_r.data);
            chk("f_err", {31'b0, ifc.f_err}, {31'b0, mon_r.err});
            last_f = mon_r.data;
         end
      end else begin
         chk("f_err_idle", {31'b0, ifc.f_err}, 32'h0);
         chk("f_rdata_hold", ifc.f_rdata, last_f);
      end
      if (ifc.d_rvalid === 1'b1) begin
         if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL d_unexpected_rvalid actual=1 expected=0");
         end else begin
            mon_r = dq.pop_front();
            chk("d_rdata", ifc.d_rdata, mon_r.data);
            chk("d_err", {31'b0, ifc.d_err}, {31'b0, mon_r.err});
            last_d = mon_r.data;
         end
      end else begin
         chk("d_err_idle", {31'b0, ifc.d_err}, 32'h0);
         chk("d_rdata_hold", ifc.d_rdata, last_d);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic gf, gd;
      logic fr, dr, f_hold, d_hold;
      logic [31:0] fa, da;
      errors = 0; checks = 0; cnt_m = 0;
      last_f = 32'h0; last_d = 32'h0;
      for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
      reset = 1'b0;
      ifc.f_req = 1'b1; ifc.f_adr = 32'h0;
      ifc.d_req = 1'b1; ifc.d_adr = 32'h4;
      #2;
      chk("rst_f_gnt", {31'b0, ifc.f_gnt}, 32'h0);
      chk("rst_d_gnt", {31'b0, ifc.d_gnt}, 32'h0);
      chk("rst_f_rvalid", {31'b0, ifc.f_rvalid}, 32'h0);
      chk("rst_d_rdata", ifc.d_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Fetch-only streaming.
      cycle(1'b1, 32'h0, 1'b0, 32'h0, gf, gd);
      cycle(1'b1, 32'h4, 1'b0, 32'h0, gf, gd);
      cycle(1'b1, 32'h8, 1'b0, 32'h0, gf, gd);
      // Debug boundary: last valid word, then first invalid.
      cycle(1'b0, 32'h0, 1'b1, 32'h0000_00FC, gf, gd);
      cycle(1'b0, 32'h0, 1'b1, 32'h0000_0100, gf, gd);
      cycle(1'b0, 32'h0, 1'b1, 32'h8000_0000, gf, gd);
      // Misaligned fetch.
      cycle(1'b1, 32'h0000_0006, 1'b0, 32'h0, gf, gd);
      // Idle.
      cycle(1'b0, 32'h40, 1'b0, 32'h8, gf, gd);
      cycle(1'b0, 32'h44, 1'b0, 32'h8, gf, gd);

      // Contention: debug should win every fifth cycle.
      for (int k = 0; k < 15; k++) begin
         cycle(1'b1, 32'(k * 4), 1'b1, 32'h0000_00F0, gf, gd);
         chk("contention_d_gnt", {31'b0, gd}, {31'b0, (k % 5) == 4});
      end

      // Reset between the grant edge and the response.
      cycle(1'b1, 32'h10, 1'b1, 32'h14, gf, gd);
      cycle(1'b1, 32'h10, 1'b1, 32'h14, gf, gd);
      reset = 1'b0;
      #1;
      chk("arst_f_rvalid", {31'b0, ifc.f_rvalid}, 32'h0);
      chk("arst_d_rvalid", {31'b0, ifc.d_rvalid}, 32'h0);
      fq.delete(); dq.delete();
      last_f = 32'h0; last_d = 32'h0; cnt_m = 0;
      cycle(1'b1, 32'h20, 1'b1, 32'h24, gf, gd);
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, 32'h20, 1'b1, 32'h24, gf, gd);
         chk("post_rst_d_gnt", {31'b0, gd}, {31'b0, k == 4});
      end

      // Randomized traffic obeying the hold-until-grant rule.
      f_hold = 1'b0; d_hold = 1'b0;
      fr = 1'b0; dr = 1'b0; fa = 32'h0; da = 32'h0;
      for (int i = 0; i < 400; i++) begin
         if (!f_hold) begin
            fr = ($urandom_range(0, 3) != 0);
            fa = rand_adr();
         end
         if (!d_hold) begin
            dr = ($urandom_range(0, 2) != 0);
            da = rand_adr();
         end
         cycle(fr, fa, dr, da, gf, gd);
         f_hold = fr && !gf;
         d_hold = dr && !gd;
      end

      cycle(1'b0, 32'h0, 1'b0, 32'h0, gf, gd);
      cycle(1'b0, 32'h0, 1'b0, 32'h0, gf, gd);
      chk("f_queue_drained", 32'(fq.size()), 32'h0);
      chk("d_queue_drained", 32'(dq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imem_arb.md
Name: imem_arb

Overview:
Arbiter and sequencer for the single read port of the instruction memory. It shares that port between the pipeline fetch stage and a debug/test read port. It grants at most one read per cycle and returns registered read data one cycle after the grant. It flags out-of-range and misaligned addresses instead of passing undefined data. It sits between the fetch stage, the debug port, and the instruction memory's combinational read port.

Parameters:
SIZE, 64, instruction memory depth in 32-bit words; word index adr[31:2] must be < SIZE.
MAX_WAIT, 4, consecutive debug-losing cycles after which debug wins the next contention; range 1..15.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
f_req  input  1  fetch read request
f_adr  input  32  fetch byte address
f_gnt  output  1  fetch request accepted this cycle (combinational)
f_rvalid  output  1  fetch read data valid
f_rdata  output  32  fetch read data
f_err  output  1  fetch response error (out of range or misaligned)
d_req  input  1  debug read request
d_adr  input  32  debug byte address
d_gnt  output  1  debug request accepted this cycle (combinational)
d_rvalid  output  1  debug read data valid
d_rdata  output  32  debug read data
d_err  output  1  debug response error
mem_adr  output  32  byte address to instruction memory read port
mem_rd  input  32  combinational read data from instruction memory

Behaviour:
- Reset (reset low, asynchronous):
  - f_rvalid, d_rvalid, f_err and d_err go to 0.
  - f_rdata and d_rdata go to 32'h0.
  - Starvation counter clears to 0; FSM goes to IDLE.
  - f_gnt and d_gnt are 0 while reset is low.
- Grant logic (combinational, at most one of f_gnt/d_gnt high):
  - Only f_req high: f_gnt = 1.
  - Only d_req high: d_gnt = 1.
  - Both high: f_gnt = 1 unless starvation counter == MAX_WAIT, in which case d_gnt = 1.
  - Neither high: no grant.
- mem_adr:
  - Equals the granted requester's address.
  - With no grant, mem_adr = f_adr, for a stable idle address.
- Starvation counter (4 bits):
  - Increments when d_req is high and fetch is granted.
  - Clears when debug is granted or d_req is low.
  - Saturates at MAX_WAIT.
- Request rules:
  - A requester holds req high until it sees gnt.
  - The address may change only while gnt is low.
  - A request is accepted on the clock edge where req && gnt.
- Response, fixed latency of 1 cycle:
  - On the accepting edge, the granted side's rvalid becomes 1 for exactly one cycle.
  - On that same edge, rdata registers mem_rd.
  - The other side's rvalid is 0 that cycle.
- Error:
  - err = (adr[31:2] >= SIZE) || (adr[1:0] != 2'b00), evaluated on the granted address.
  - On error, rdata = 32'h0 (never X) and err = 1 alongside rvalid.
  - err is 0 whenever rvalid is 0.
- rdata holds its last value when rvalid is 0.
- FSM (state = owner of the response presented this cycle):
  - States: IDLE, F_RESP, D_RESP.
  - Next state is F_RESP if fetch is granted, D_RESP if debug is granted, else IDLE, from any state.
  - Back-to-back grants are allowed every cycle, giving full throughput.
- Simultaneous events:
  - A grant in the same cycle a response is presented is legal; both proceed.
  - Requests on both sides are serialized by the priority rule above.
- Reset mid-operation: a pending response is dropped (rvalid forced 0), with no response after reset release.
- Address boundaries:
  - Word index SIZE-1 (byte 4*SIZE-4) is valid.
  - Word index SIZE is an error.
  - Upper address bits are not ignored, so 32'h8000_0000 is an error.

Test Plan:
- Fetch only, f_adr = 0, 4, 8 on consecutive cycles with mem words 0x11,0x22,0x33 -> f_gnt = 1 each cycle; f_rvalid = 1 on the three following cycles with f_rdata = 0x11,0x22,0x33; d_rvalid stays 0.
- Debug only, d_adr = 32'h0000_00FC (word 63, SIZE = 64) -> d_gnt = 1; next cycle d_rvalid = 1, d_err = 0, d_rdata = RAM[63]. Then d_adr = 32'h0000_0100 -> d_rvalid = 1, d_err = 1, d_rdata = 0.
- Misaligned fetch, f_adr = 32'h0000_0006 -> f_rvalid = 1, f_err = 1, f_rdata = 0.
- Contention, f_req and d_req held high continuously with MAX_WAIT = 4 -> fetch granted 4 cycles, debug granted on the 5th, fetch for the next 4, and so on. mem_adr tracks the granted address every cycle.
- Reset asserted asynchronously between a grant edge and the response -> f_rvalid/d_rvalid = 0 immediately. No response appears after release; the counter reads 0, shown by debug losing the next 4 contention cycles.
- Idle, no requests -> f_gnt = d_gnt = 0, rvalids 0, rdata unchanged, mem_adr = f_adr.
